// File: rtl/perceptron_trainer.sv
// Perceptron-rule trainer for a 2-input neuron: runs epochs over a latched 4-entry
// truth table, updating saturating signed weights/bias until an error-free epoch or the epoch limit.
module perceptron_trainer #(
  parameter int W          = 8,
  parameter int LR         = 1,
  parameter int MAX_EPOCHS = 64,
  parameter int INIT_W0    = 0,
  parameter int INIT_W1    = 0,
  parameter int INIT_BIAS  = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [3:0]   target,
  output logic [W-1:0] w0,
  output logic [W-1:0] w1,
  output logic [W-1:0] bias,
  output logic         busy,
  output logic         done,
  output logic         converged,
  output logic [7:0]   epoch_count
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CHECK, DONE} state_t;

  localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};
  localparam logic signed [W+1:0] STEP = LR[W+1:0];
  localparam logic [W-1:0]        IW0  = INIT_W0[W-1:0];
  localparam logic [W-1:0]        IW1  = INIT_W1[W-1:0];
  localparam logic [W-1:0]        IB   = INIT_BIAS[W-1:0];
  localparam logic [7:0]          MAXE = MAX_EPOCHS[7:0];

  state_t       state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [3:0]   tgt_q, tgt_d;
  logic [W-1:0] w0_q, w0_d, w1_q, w1_d, bias_q, bias_d;
  logic [2:0]   err_cnt_q, err_cnt_d;
  logic [7:0]   epoch_q, epoch_d;
  logic         busy_q, busy_d, done_q, done_d, conv_q, conv_d;

  logic                x0, x1, y, t;
  logic signed [W+1:0] sum, delta;

  // Sign-extend, add, and clamp to the W-bit signed range instead of wrapping.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                           input logic signed [W+1:0] d);
    logic signed [W+1:0] s;
    s = signed'({{2{a[W-1]}}, a}) + d;
    if (s > MAXV) return MAXV[W-1:0];
    if (s < MINV) return MINV[W-1:0];
    return s[W-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tgt_d     = tgt_q;
    w0_d      = w0_q;
    w1_d      = w1_q;
    bias_d    = bias_q;
    err_cnt_d = err_cnt_q;
    epoch_d   = epoch_q;
    busy_d    = busy_q;
    done_d    = done_q;
    conv_d    = conv_q;

    x0  = idx_q[1];
    x1  = idx_q[0];
    sum = (x0 ? signed'({{2{w0_q[W-1]}}, w0_q}) : '0)
        + (x1 ? signed'({{2{w1_q[W-1]}}, w1_q}) : '0)
        + signed'({{2{bias_q[W-1]}}, bias_q});
    y     = !sum[W+1] && (sum != '0);
    t     = tgt_q[idx_q];
    delta = t ? STEP : -STEP;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SAMPLE;
          tgt_d     = target;
          w0_d      = IW0;
          w1_d      = IW1;
          bias_d    = IB;
          epoch_d   = '0;
          err_cnt_d = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          conv_d    = 1'b0;
        end
      end
      SAMPLE: begin
        if (t != y) begin
          if (x0) w0_d = sat_add(w0_q, delta);
          if (x1) w1_d = sat_add(w1_q, delta);
          bias_d    = sat_add(bias_q, delta);
          err_cnt_d = err_cnt_q + 3'd1;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = CHECK;
      end
      CHECK: begin
        epoch_d = epoch_q + 8'd1;
        if (err_cnt_q == '0 || epoch_d == MAXE) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          conv_d  = (err_cnt_q == '0);
        end else begin
          state_d   = SAMPLE;
          err_cnt_d = '0;
          idx_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tgt_q     <= '0;
      w0_q      <= IW0;
      w1_q      <= IW1;
      bias_q    <= IB;
      err_cnt_q <= '0;
      epoch_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tgt_q     <= tgt_d;
      w0_q      <= w0_d;
      w1_q      <= w1_d;
      bias_q    <= bias_d;
      err_cnt_q <= err_cnt_d;
      epoch_q   <= epoch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      conv_q    <= conv_d;
    end
  end

  assign w0          = w0_q;
  assign w1          = w1_q;
  assign bias        = bias_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign converged   = conv_q;
  assign epoch_count = epoch_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: three instances (defaults, XOR with
// 16-epoch limit, saturation config) checked against hand-computed results.
module tb_perceptron_trainer;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic              start_a, start_x, start_s;
  logic [3:0]        tgt_a, tgt_x, tgt_s;
  logic signed [7:0] w0_a, w1_a, b_a, w0_x, w1_x, b_x, w0_s, w1_s, b_s;
  logic              busy_a, done_a, conv_a, busy_x, done_x, conv_x, busy_s, done_s, conv_s;
  logic [7:0]        ep_a, ep_x, ep_s;

  int n_checks = 0;
  int n_fail   = 0;

  perceptron_trainer u_a (
    .Clk(Clk), .Reset(Reset), .start(start_a), .target(tgt_a),
    .w0(w0_a), .w1(w1_a), .bias(b_a), .busy(busy_a), .done(done_a),
    .converged(conv_a), .epoch_count(ep_a)
  );

  perceptron_trainer #(.MAX_EPOCHS(16)) u_x (
    .Clk(Clk), .Reset(Reset), .start(start_x), .target(tgt_x),
    .w0(w0_x), .w1(w1_x), .bias(b_x), .busy(busy_x), .done(done_x),
    .converged(conv_x), .epoch_count(ep_x)
  );

  perceptron_trainer #(.LR(100), .INIT_W1(100), .INIT_BIAS(-128)) u_s (
    .Clk(Clk), .Reset(Reset), .start(start_s), .target(tgt_s),
    .w0(w0_s), .w1(w1_s), .bias(b_s), .busy(busy_s), .done(done_s),
    .converged(conv_s), .epoch_count(ep_s)
  );

  // Starts a run on the default instance and returns the edge count to done (-1 on timeout).
  // A nonzero mid pulses start (with a different target) on that edge of the run.
  task automatic run_a(input logic [3:0] t, input int mid, output int edges);
    tgt_a = t;
    @(negedge Clk);
    start_a = 1'b1;
    @(posedge Clk);
    #1;
    start_a = 1'b0;
    edges = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge Clk);
      #1;
      if (done_a) begin
        edges = k;
        break;
      end
      if (k == mid) begin
        start_a = 1'b1;
        tgt_a   = 4'b0110;
      end else begin
        start_a = 1'b0;
      end
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    start_a = 1'b0; start_x = 1'b0; start_s = 1'b0;
    tgt_a = '0; tgt_x = '0; tgt_s = '0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if ({busy_a, done_a, conv_a} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy_a, done_a, conv_a});
    end
    n_checks++;
    if (ep_a !== 8'd0) begin
      n_fail++; $display("FAIL reset_epoch: got %0d expected 0", ep_a);
    end
    n_checks++;
    if ({w0_a, w1_a, b_a} !== 24'h000000) begin
      n_fail++; $display("FAIL reset_weights: got %0d/%0d/%0d expected 0/0/0", w0_a, w1_a, b_a);
    end
    n_checks++;
    if (int'(w1_s) !== 100 || int'(b_s) !== -128 || int'(w0_s) !== 0) begin
      n_fail++; $display("FAIL reset_init: got %0d/%0d/%0d expected 0/100/-128", w0_s, w1_s, b_s);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_and();
    int e, s, y;
    run_a(4'b1000, 0, e);
    n_checks++;
    if (e !== 30) begin
      n_fail++; $display("FAIL and_latency: got %0d expected 30", e);
    end
    n_checks++;
    if (conv_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL and_flags: conv=%b busy=%b expected conv=1 busy=0", conv_a, busy_a);
    end
    n_checks++;
    if (ep_a !== 8'd6) begin
      n_fail++; $display("FAIL and_epochs: got %0d expected 6", ep_a);
    end
    n_checks++;
    if (int'(w0_a) !== 2 || int'(w1_a) !== 1 || int'(b_a) !== -2) begin
      n_fail++; $display("FAIL and_weights: got %0d/%0d/%0d expected 2/1/-2", w0_a, w1_a, b_a);
    end
    for (int p = 0; p < 4; p++) begin
      s = int'(w0_a) * (p >> 1) + int'(w1_a) * (p & 1) + int'(b_a);
      y = (s > 0) ? 1 : 0;
      n_checks++;
      if (y !== ((p == 3) ? 1 : 0)) begin
        n_fail++; $display("FAIL and_neuron[%0d]: got %0d expected %0d", p, y, (p == 3) ? 1 : 0);
      end
    end
    repeat (4) @(posedge Clk);
    #1;
    n_checks++;
    if (done_a !== 1'b1 || int'(w0_a) !== 2 || int'(b_a) !== -2 || ep_a !== 8'd6) begin
      n_fail++; $display("FAIL and_hold: done=%b w0=%0d bias=%0d ep=%0d expected 1/2/-2/6",
                         done_a, w0_a, b_a, ep_a);
    end
  endtask

  task automatic test_trivial();
    int e;
    run_a(4'b0000, 0, e);
    n_checks++;
    if (e !== 5) begin
      n_fail++; $display("FAIL triv_latency: got %0d expected 5", e);
    end
    n_checks++;
    if (conv_a !== 1'b1 || ep_a !== 8'd1) begin
      n_fail++; $display("FAIL triv_result: conv=%b ep=%0d expected 1/1", conv_a, ep_a);
    end
    n_checks++;
    if ({w0_a, w1_a, b_a} !== 24'h000000) begin
      n_fail++; $display("FAIL triv_weights: got %0d/%0d/%0d expected 0/0/0", w0_a, w1_a, b_a);
    end
  endtask

  task automatic test_xor();
    int e, busy_gaps;
    e = -1;
    busy_gaps = 0;
    tgt_x = 4'b0110;
    @(negedge Clk);
    start_x = 1'b1;
    @(posedge Clk);
    #1;
    start_x = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge Clk);
      #1;
      if (done_x) begin
        e = k;
        break;
      end
      if (!busy_x) busy_gaps++;
    end
    n_checks++;
    if (e !== 80) begin
      n_fail++; $display("FAIL xor_latency: got %0d expected 80", e);
    end
    n_checks++;
    if (busy_gaps !== 0) begin
      n_fail++; $display("FAIL xor_busy: %0d cycles low, expected 0", busy_gaps);
    end
    n_checks++;
    if (conv_x !== 1'b0 || ep_x !== 8'd16 || busy_x !== 1'b0) begin
      n_fail++; $display("FAIL xor_result: conv=%b ep=%0d busy=%b expected 0/16/0", conv_x, ep_x, busy_x);
    end
  endtask

  task automatic test_saturation();
    tgt_s = 4'b0010;
    @(negedge Clk);
    start_s = 1'b1;
    @(posedge Clk);
    #1;
    start_s = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if (int'(w0_s) !== 0 || int'(w1_s) !== 127 || int'(b_s) !== -28) begin
      n_fail++; $display("FAIL sat_step2: got %0d/%0d/%0d expected 0/127/-28", w0_s, w1_s, b_s);
    end
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if (int'(w0_s) !== -100 || int'(w1_s) !== 27 || int'(b_s) !== -128) begin
      n_fail++; $display("FAIL sat_step4: got %0d/%0d/%0d expected -100/27/-128", w0_s, w1_s, b_s);
    end
  endtask

  task automatic test_control();
    int e;
    run_a(4'b1000, 7, e);
    n_checks++;
    if (e !== 30 || ep_a !== 8'd6 || conv_a !== 1'b1) begin
      n_fail++; $display("FAIL ctl_midstart: edges=%0d ep=%0d conv=%b expected 30/6/1", e, ep_a, conv_a);
    end
    n_checks++;
    if (int'(w0_a) !== 2 || int'(w1_a) !== 1 || int'(b_a) !== -2) begin
      n_fail++; $display("FAIL ctl_midstart_w: got %0d/%0d/%0d expected 2/1/-2", w0_a, w1_a, b_a);
    end

    tgt_a = 4'b1000;
    @(negedge Clk);
    start_a = 1'b1;
    @(posedge Clk);
    #1;
    start_a = 1'b0;
    repeat (7) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || ep_a !== 8'd0 || {w0_a, w1_a, b_a} !== 24'h000000) begin
      n_fail++; $display("FAIL ctl_reset: busy=%b done=%b ep=%0d w=%0d/%0d/%0d expected 0/0/0 0/0/0",
                         busy_a, done_a, ep_a, w0_a, w1_a, b_a);
    end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL ctl_idle: busy=%b done=%b expected 0/0", busy_a, done_a);
    end

    run_a(4'b1000, 0, e);
    run_a(4'b1000, 0, e);
    n_checks++;
    if (e !== 30 || ep_a !== 8'd6 || conv_a !== 1'b1) begin
      n_fail++; $display("FAIL ctl_rerun: edges=%0d ep=%0d conv=%b expected 30/6/1", e, ep_a, conv_a);
    end
    n_checks++;
    if (int'(w0_a) !== 2 || int'(w1_a) !== 1 || int'(b_a) !== -2) begin
      n_fail++; $display("FAIL ctl_rerun_w: got %0d/%0d/%0d expected 2/1/-2", w0_a, w1_a, b_a);
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_trivial();
    test_xor();
    test_saturation();
    test_control();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
